// File: rtl/a2_instr_loader.sv
// Instruction loader: accepts a program word-by-word over a valid/ready port into a small
// memory, holds the datapath in reset until a complete program is present, and serves fetch reads.
module a2_instr_loader #(
  parameter int          DEPTH = 16,
  parameter logic [7:0]  FILL  = 8'h00,
  localparam int         AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          in_ready,
  input  logic          reload,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          dp_reset,
  output logic [AW:0]   load_count,
  output logic          done,
  output logic          error,
  output logic [1:0]    state_dbg
);

  // Handshake: a word transfers on a rising edge where in_valid and in_ready are both 1.
  // The producer holds in_data/in_last stable while in_valid=1 and in_ready=0.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  state_t     state;
  logic       accept;
  logic [7:0] mem [DEPTH];

  assign in_ready  = (state == IDLE) || (state == LOAD);
  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      load_count <= '0;
      dp_reset   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            load_count <= load_count + 1'b1;
            if (in_last) begin
              state    <= RUN;
              dp_reset <= 1'b0;
              done     <= 1'b1;
            end else if (load_count == LAST_IDX) begin
              // Memory is full and the program has not ended.
              state <= ERR;
              error <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        RUN, ERR: begin
          if (reload) begin
            state      <= IDLE;
            load_count <= '0;
            dp_reset   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          load_count <= '0;
          dp_reset   <= 1'b1;
          done       <= 1'b0;
          error      <= 1'b0;
        end
      endcase
    end
  end

  // Storage is never cleared; stale words beyond load_count are masked on read.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      mem[load_count[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= 8'h00;
    end else if ({1'b0, rd_addr} >= load_count) begin
      rd_data <= FILL;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_a2_instr_loader.sv
// Self-checking bench for a2_instr_loader: directed load scenarios with a read scoreboard
// fed from a reference copy of the loaded program.
module tb_a2_instr_loader;

  localparam int         DEPTH = 16;
  localparam int         AW    = 4;
  localparam logic [7:0] FILL  = 8'h00;
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_ERR = 2'd3;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic          reload;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          dp_reset;
  logic [AW:0]   load_count;
  logic          done;
  logic          error;
  logic [1:0]    state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_mem [DEPTH];
  int         model_count;

  // {done, error, dp_reset, in_ready, state, load_count}
  wire [10:0] status = {done, error, dp_reset, in_ready, state_dbg, load_count};

  a2_instr_loader #(.DEPTH(DEPTH), .FILL(FILL)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .reload     (reload),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dp_reset   (dp_reset),
    .load_count (load_count),
    .done       (done),
    .error      (error),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] mk(input logic d, input logic e, input logic dp,
                                     input logic rdy, input logic [1:0] st, input int cnt);
    return {d, e, dp, rdy, st, 5'(cnt)};
  endfunction

  task automatic send_word(input logic [7:0] d, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout in_ready=%b required=1 word=%h", in_ready, d);
    end else begin
      model_mem[model_count] = d;
      model_count++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic read_check(input logic [AW-1:0] a);
    logic [7:0] exp;
    logic [7:0] got_exp;
    exp = (int'(a) < model_count) ? model_mem[a] : FILL;
    rd_addr = a;
    exp_q.push_back(exp);
    @(negedge clk);
    got_exp = exp_q.pop_front();
    checks++;
    if (rd_data !== got_exp) begin
      failures++;
      $display("FAIL read addr=%0d got=%h required=%h", a, rd_data, got_exp);
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    model_count = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    reload = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);
    model_count = 0;
    checks++;
    if (status !== mk(0, 0, 1, 1, S_IDLE, 0)) begin
      failures++;
      $display("FAIL reset_status got=%b required=%b", status, mk(0, 0, 1, 1, S_IDLE, 0));
    end
    checks++;
    if (rd_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_rd_data got=%h required=00", rd_data);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_three_word();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    checks++;
    if (status !== mk(0, 0, 1, 1, S_LOAD, 2)) begin
      failures++;
      $display("FAIL three_word_mid got=%b required=%b", status, mk(0, 0, 1, 1, S_LOAD, 2));
    end
    send_word(8'h33, 1'b1);
    checks++;
    if (status !== mk(1, 0, 0, 0, S_RUN, 3)) begin
      failures++;
      $display("FAIL three_word_run got=%b required=%b", status, mk(1, 0, 0, 0, S_RUN, 3));
    end
    for (int a = 0; a < 4; a++) read_check(AW'(a));
  endtask

  task automatic test_overflow();
    do_reload();
    checks++;
    if (status !== mk(0, 0, 1, 1, S_IDLE, 0)) begin
      failures++;
      $display("FAIL reload_idle got=%b required=%b", status, mk(0, 0, 1, 1, S_IDLE, 0));
    end
    for (int i = 0; i < DEPTH; i++) send_word(8'($urandom_range(0, 255)), 1'b0);
    checks++;
    if (status !== mk(0, 1, 1, 0, S_ERR, DEPTH)) begin
      failures++;
      $display("FAIL overflow_err got=%b required=%b", status, mk(0, 1, 1, 0, S_ERR, DEPTH));
    end
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (status !== mk(0, 1, 1, 0, S_ERR, DEPTH)) begin
      failures++;
      $display("FAIL overflow_hold got=%b required=%b", status, mk(0, 1, 1, 0, S_ERR, DEPTH));
    end
    read_check(AW'(0));
    read_check(AW'(DEPTH - 1));
    for (int i = 0; i < 4; i++) read_check(AW'($urandom_range(1, DEPTH - 2)));
  endtask

  task automatic test_one_word();
    do_reload();
    send_word(8'hA5, 1'b1);
    checks++;
    if (status !== mk(1, 0, 0, 0, S_RUN, 1)) begin
      failures++;
      $display("FAIL one_word_run got=%b required=%b", status, mk(1, 0, 0, 0, S_RUN, 1));
    end
    read_check(AW'(0));
    read_check(AW'(5));
  endtask

  task automatic test_reload();
    do_reload();
    for (int i = 0; i < 5; i++) send_word(8'hC0 + 8'(i), (i == 4));
    checks++;
    if (status !== mk(1, 0, 0, 0, S_RUN, 5)) begin
      failures++;
      $display("FAIL reload_first got=%b required=%b", status, mk(1, 0, 0, 0, S_RUN, 5));
    end
    do_reload();
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b1);
    checks++;
    if (status !== mk(1, 0, 0, 0, S_RUN, 2)) begin
      failures++;
      $display("FAIL reload_second got=%b required=%b", status, mk(1, 0, 0, 0, S_RUN, 2));
    end
    for (int a = 0; a < 4; a++) read_check(AW'(a));
  endtask

  task automatic test_mid_reset();
    do_reload();
    rd_addr = '0;
    for (int i = 0; i < 4; i++) send_word(8'h70 + 8'(i), 1'b0);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    model_count = 0;
    checks++;
    if (status !== mk(0, 0, 1, 1, S_IDLE, 0)) begin
      failures++;
      $display("FAIL mid_reset got=%b required=%b", status, mk(0, 0, 1, 1, S_IDLE, 0));
    end
    checks++;
    if (rd_data !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset_rd_data got=%h required=00", rd_data);
    end
    send_word(8'h3C, 1'b0);
    send_word(8'h4D, 1'b1);
    checks++;
    if (status !== mk(1, 0, 0, 0, S_RUN, 2)) begin
      failures++;
      $display("FAIL mid_reset_fresh got=%b required=%b", status, mk(1, 0, 0, 0, S_RUN, 2));
    end
    for (int a = 0; a < 4; a++) read_check(AW'(a));
  endtask

  task automatic test_gaps();
    logic [7:0] exp;
    logic [7:0] got_exp;
    do_reload();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) begin
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
      end
      checks++;
      if (load_count !== 5'(i) || state_dbg !== ((i == 0) ? S_IDLE : S_LOAD)) begin
        failures++;
        $display("FAIL gaps_count word=%0d got=%0d/%0d required=%0d", i, load_count, state_dbg, i);
      end
      // Read the previously written word while the next one is being stored.
      rd_addr = AW'((i == 0) ? 0 : i - 1);
      exp = (i == 0) ? FILL : model_mem[i - 1];
      exp_q.push_back(exp);
      send_word(8'($urandom_range(0, 255)), (i == 5));
      got_exp = exp_q.pop_front();
      checks++;
      if (rd_data !== got_exp) begin
        failures++;
        $display("FAIL gaps_rw word=%0d got=%h required=%h", i, rd_data, got_exp);
      end
    end
    checks++;
    if (status !== mk(1, 0, 0, 0, S_RUN, 6)) begin
      failures++;
      $display("FAIL gaps_run got=%b required=%b", status, mk(1, 0, 0, 0, S_RUN, 6));
    end
    for (int a = 0; a < 8; a++) read_check(AW'(a));
  endtask

  initial begin
    test_reset();
    test_three_word();
    test_overflow();
    test_one_word();
    test_reload();
    test_mid_reset();
    test_gaps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
